// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and constants for uart_param_core
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Parity bit to transmit (or expect) given the XOR-reduction of the data.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        if (mode == int'(PARITY_ODD)) begin
            return ~data_xor;
        end else if (mode == int'(PARITY_EVEN)) begin
            return data_xor;
        end
        return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick_gen.sv
`default_nettype none
// ============================================================================
// uart_tick_gen : 16x oversampling tick, period BaudDiv+1 clock cycles
// Revision : 1.0
// ============================================================================
module uart_tick_gen #(
    parameter int DIV_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [DIV_W-1:0] BaudDiv,
    output logic             Tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_load;

    // Reset holds a constant; the first cycle after reset loads BaudDiv.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt  <= '0;
            r_load <= 1'b1;
        end else if (r_load || (r_cnt == '0)) begin
            r_cnt  <= BaudDiv;
            r_load <= 1'b0;
        end else begin
            r_cnt  <= r_cnt - DIV_W'(1);
        end
    end

    assign Tick = !r_load && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_param_core.sv
`default_nettype none
// ============================================================================
// uart_param_core : parametrised full-duplex UART, independent TX/RX FSMs
// Revision : 1.0
// ============================================================================
module uart_param_core
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIV_W     = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DIV_W-1:0]  BaudDiv,
    input  logic [DATA_W-1:0] TxData,
    input  logic              TxValid,
    output logic              TxReady,
    output logic              TxDone,
    output logic              Tx,
    input  logic              Rx,
    output logic [DATA_W-1:0] RxData,
    output logic              RxValid,
    output logic              RxParityErr,
    output logic              RxFrameErr
);

    localparam logic [3:0] c_WIN_LAST     = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] c_MID          = 4'(MID_SAMPLE);
    localparam logic [4:0] c_TX_WIN_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] c_TX_STOP_LAST = 5'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [3:0] c_BIT_LAST     = 4'(DATA_W - 1);
    localparam bit         c_HAS_PAR      = (PARITY != 0);

    logic w_tick;

    uart_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .BaudDiv (BaudDiv),
        .Tick    (w_tick)
    );

    // ------------------------------------------------------------------ TX
    tx_state_e         r_tx_state, w_tx_next;
    logic [4:0]        r_tx_cnt;
    logic [3:0]        r_tx_bit;
    logic [DATA_W-1:0] r_tx_shift;
    logic              r_tx_par;
    logic              w_tx_accept;
    logic              w_tx_win_end;

    // STOP is one long window covering all stop bits.
    assign w_tx_win_end = w_tick &&
        (r_tx_cnt == ((r_tx_state == TX_STOP) ? c_TX_STOP_LAST : c_TX_WIN_LAST));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:   if (w_tx_accept)  w_tx_next = TX_START;
            TX_START:  if (w_tx_win_end) w_tx_next = TX_DATA;
            TX_DATA:   if (w_tx_win_end && (r_tx_bit == c_BIT_LAST))
                           w_tx_next = c_HAS_PAR ? TX_PARITY : TX_STOP;
            TX_PARITY: if (w_tx_win_end) w_tx_next = TX_STOP;
            TX_STOP:   if (w_tx_win_end) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        TxReady     = (r_tx_state == TX_IDLE);
        TxDone      = (r_tx_state == TX_STOP) && w_tx_win_end;
        w_tx_accept = TxReady && TxValid;
        case (r_tx_state)
            TX_START:  Tx = 1'b0;
            TX_DATA:   Tx = r_tx_shift[0];
            TX_PARITY: Tx = r_tx_par;
            default:   Tx = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_shift <= TxData;
            r_tx_par   <= parity_bit(^TxData, PARITY);
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else if (w_tick && (r_tx_state != TX_IDLE)) begin
            if (w_tx_win_end) begin
                r_tx_cnt <= '0;
                if (r_tx_state == TX_DATA) begin
                    r_tx_shift <= r_tx_shift >> 1;
                    r_tx_bit   <= r_tx_bit + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 5'd1;
            end
        end
    end

    // ------------------------------------------------------------------ RX
    logic              r_rx_meta, r_rx_sync;
    rx_state_e         r_rx_state, w_rx_next;
    logic [3:0]        r_rx_cnt;
    logic [3:0]        r_rx_bit;
    logic [DATA_W-1:0] r_rx_shift;
    logic              r_rx_par;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid, r_rx_perr, r_rx_ferr;
    logic              w_rx_mid, w_rx_win_end, w_rx_done, w_rx_perr;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= Rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:   if (!r_rx_sync) w_rx_next = RX_START;
            RX_START:  begin
                if (w_rx_mid && r_rx_sync) w_rx_next = RX_IDLE;
                else if (w_rx_win_end)     w_rx_next = RX_DATA;
            end
            RX_DATA:   if (w_rx_win_end && (r_rx_bit == c_BIT_LAST))
                           w_rx_next = c_HAS_PAR ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_win_end) w_rx_next = RX_STOP;
            // Frame ends at the first stop sample; a low line parks in BREAK.
            RX_STOP:   if (w_rx_mid) w_rx_next = r_rx_sync ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (r_rx_sync) w_rx_next = RX_IDLE;
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_mid     = w_tick && (r_rx_cnt == c_MID);
        w_rx_win_end = w_tick && (r_rx_cnt == c_WIN_LAST);
        w_rx_done    = (r_rx_state == RX_STOP) && w_rx_mid;
        w_rx_perr    = c_HAS_PAR && (parity_bit(^r_rx_shift, PARITY) != r_rx_par);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            if ((r_rx_state == RX_IDLE) || (r_rx_state == RX_BREAK)) begin
                r_rx_cnt <= '0;
                r_rx_bit <= '0;
            end else if (w_tick) begin
                r_rx_cnt <= r_rx_cnt + 4'd1;
                if ((r_rx_state == RX_DATA) && w_rx_win_end) r_rx_bit <= r_rx_bit + 4'd1;
            end
            if ((r_rx_state == RX_DATA) && w_rx_mid)
                r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_W-1:1]};
            if ((r_rx_state == RX_PARITY) && w_rx_mid)
                r_rx_par <= r_rx_sync;
            if (w_rx_done) r_rx_data <= r_rx_shift;
            r_rx_valid <= w_rx_done;
            r_rx_perr  <= w_rx_done && w_rx_perr;
            r_rx_ferr  <= w_rx_done && !r_rx_sync;
        end
    end

    assign RxData      = r_rx_data;
    assign RxValid     = r_rx_valid;
    assign RxParityErr = r_rx_perr;
    assign RxFrameErr  = r_rx_ferr;

endmodule
`default_nettype wire

// File: tb/tb_uart_param_core.sv
`default_nettype none
// ============================================================================
// tb_uart_param_core : directed vectors on 8N1, 7E2 and 8O1 instances
// Revision : 1.0
// ============================================================================
module tb_uart_param_core;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] baud;
    logic        tx_valid [3];
    logic [8:0]  tx_data  [3];
    logic        rx_drv0, rx_drv2, loop0;
    logic        tx_w [3], ready_w [3], done_w [3], rxv_w [3], perr_w [3], ferr_w [3];
    logic [7:0]  rxd0, rxd2;
    logic [6:0]  rxd1;
    logic        rx_in0;

    assign rx_in0 = loop0 ? tx_w[0] : rx_drv0;

    uart_param_core #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) dut0 (
        .Clk(clk), .Rst_n(rst_n), .BaudDiv(baud), .TxData(tx_data[0][7:0]),
        .TxValid(tx_valid[0]), .TxReady(ready_w[0]), .TxDone(done_w[0]), .Tx(tx_w[0]),
        .Rx(rx_in0), .RxData(rxd0), .RxValid(rxv_w[0]), .RxParityErr(perr_w[0]),
        .RxFrameErr(ferr_w[0]));

    uart_param_core #(.DATA_W(7), .PARITY(2), .STOP_BITS(2), .DIV_W(16)) dut1 (
        .Clk(clk), .Rst_n(rst_n), .BaudDiv(baud), .TxData(tx_data[1][6:0]),
        .TxValid(tx_valid[1]), .TxReady(ready_w[1]), .TxDone(done_w[1]), .Tx(tx_w[1]),
        .Rx(tx_w[1]), .RxData(rxd1), .RxValid(rxv_w[1]), .RxParityErr(perr_w[1]),
        .RxFrameErr(ferr_w[1]));

    uart_param_core #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .DIV_W(16)) dut2 (
        .Clk(clk), .Rst_n(rst_n), .BaudDiv(baud), .TxData(tx_data[2][7:0]),
        .TxValid(tx_valid[2]), .TxReady(ready_w[2]), .TxDone(done_w[2]), .Tx(tx_w[2]),
        .Rx(rx_drv2), .RxData(rxd2), .RxValid(rxv_w[2]), .RxParityErr(perr_w[2]),
        .RxFrameErr(ferr_w[2]));

    int         n_vec = 0;
    int         n_err = 0;
    int         rxv_cnt [3] = '{0, 0, 0};
    int         txd_cnt [3] = '{0, 0, 0};
    logic       last_perr [3];
    logic       last_ferr [3];
    logic [8:0] last_data [3];

    function automatic logic [8:0] get_rxd(input int i);
        case (i)
            0:       return {1'b0, rxd0};
            1:       return {2'b0, rxd1};
            default: return {1'b0, rxd2};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rxv_w[i]) begin
                rxv_cnt[i]++;
                last_perr[i] = perr_w[i];
                last_ferr[i] = ferr_w[i];
                last_data[i] = get_rxd(i);
            end
            if (done_w[i]) txd_cnt[i]++;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Sends one word; samples each line bit at the middle of its 64-cycle window.
    task automatic tx_frame(input int d, input logic [8:0] data, input int nb,
                            output logic [11:0] bits, output int idx_done);
        int b;
        bit acc;
        bits = '0; idx_done = -1; b = 0; acc = 1'b0;
        @(negedge clk);
        tx_data[d]  = data;
        tx_valid[d] = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (ready_w[d]) begin acc = 1'b1; break; end
            @(negedge clk);
        end
        if (!acc) begin
            check("tx_accept_timeout", 32'd0, 32'd1);
            tx_valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        tx_valid[d] = 1'b0;
        check("tx_start_low", 32'(tx_w[d]), 32'd0);
        for (int i = 1; i < 4000; i++) begin
            @(negedge clk);
            if ((i >= 32) && (b < nb) && (((i - 32) % 64) == 0)) begin
                bits[b] = tx_w[d];
                b++;
            end
            if (done_w[d]) begin
                idx_done = i;
                check("tx_ready_during_done", 32'(ready_w[d]), 32'd0);
                break;
            end
        end
        @(negedge clk);
        check("tx_ready_after_done", 32'(ready_w[d]), 32'd1);
    endtask

    typedef struct {
        int         d;
        int         nb;
        logic [8:0] data;
        logic [11:0] frame;
        bit         do_rx;
    } txv_t;

    typedef struct {
        logic [11:0] frame;
        logic [8:0]  data;
        logic        perr;
    } rxv_t;

    task automatic run_vec(input txv_t v);
        int r0, t0, idx;
        logic [11:0] bits;
        r0 = rxv_cnt[v.d];
        t0 = txd_cnt[v.d];
        tx_frame(v.d, v.data, v.nb, bits, idx);
        repeat (4) @(negedge clk);
        check("tx_frame_bits", 32'(bits), 32'(v.frame));
        n_vec++;
        if ((idx < 64 * v.nb - 4) || (idx > 64 * v.nb - 1)) begin
            n_err++;
            $display("FAIL tx_len: got %0d cycles expected %0d..%0d", idx, 64 * v.nb - 4, 64 * v.nb - 1);
        end
        check("tx_done_pulses", 32'(txd_cnt[v.d] - t0), 32'd1);
        if (v.do_rx) begin
            check("rx_valid_pulses", 32'(rxv_cnt[v.d] - r0), 32'd1);
            check("rx_data", 32'(last_data[v.d]), 32'(v.data));
            check("rx_perr", 32'(last_perr[v.d]), 32'd0);
            check("rx_ferr", 32'(last_ferr[v.d]), 32'd0);
        end
    endtask

    task automatic rx_drive(input int d, input logic [11:0] bits, input int nb);
        for (int b = 0; b < nb; b++) begin
            if (d == 0) rx_drv0 = bits[b];
            else        rx_drv2 = bits[b];
            repeat (64) @(negedge clk);
        end
    endtask

    txv_t tv [9];
    rxv_t rv [3];

    initial begin
        int r0;
        txv_t e7;
        // bit k of frame = k-th bit on the line (start first)
        tv[0] = '{0, 10, 9'h0A5, 12'b00_1_10100101_0, 1'b1};
        tv[1] = '{0, 10, 9'h000, 12'b00_1_00000000_0, 1'b1};
        tv[2] = '{0, 10, 9'h0FF, 12'b00_1_11111111_0, 1'b1};
        tv[3] = '{0, 10, 9'h03C, 12'b00_1_00111100_0, 1'b1};
        tv[4] = '{1, 11, 9'h055, 12'b0_1_1_0_1010101_0, 1'b1};
        tv[5] = '{1, 11, 9'h007, 12'b0_1_1_1_0000111_0, 1'b1};
        tv[6] = '{2, 11, 9'h001, 12'b0_1_0_00000001_0, 1'b0};
        tv[7] = '{2, 11, 9'h003, 12'b0_1_1_00000011_0, 1'b0};
        tv[8] = '{0, 10, 9'h0C3, 12'b00_1_11000011_0, 1'b1};
        rv[0] = '{12'b0_1_1_00000001_0, 9'h001, 1'b1};
        rv[1] = '{12'b0_1_0_00000001_0, 9'h001, 1'b0};
        rv[2] = '{12'b0_1_0_11110000_0, 9'h0F0, 1'b1};
        e7    = '{0, 10, 9'h0E7, 12'b00_1_11100111_0, 1'b1};

        rst_n = 1'b0; baud = 16'd3; loop0 = 1'b1; rx_drv0 = 1'b1; rx_drv2 = 1'b1;
        for (int i = 0; i < 3; i++) begin tx_valid[i] = 1'b0; tx_data[i] = '0; end
        repeat (3) @(negedge clk);
        check("rst_tx",       32'(tx_w[0]),    32'd1);
        check("rst_txready",  32'(ready_w[0]), 32'd1);
        check("rst_txdone",   32'(done_w[0]),  32'd0);
        check("rst_rxdata",   32'(rxd0),       32'd0);
        check("rst_rxvalid",  32'(rxv_w[0]),   32'd0);
        check("rst_perr",     32'(perr_w[0]),  32'd0);
        check("rst_ferr",     32'(ferr_w[0]),  32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(tv[i]);

        for (int i = 0; i < 3; i++) begin
            r0 = rxv_cnt[2];
            rx_drive(2, rv[i].frame, 11);
            repeat (8) @(negedge clk);
            check("par_rx_valid", 32'(rxv_cnt[2] - r0), 32'd1);
            check("par_rx_data",  32'(last_data[2]),    32'(rv[i].data));
            check("par_rx_perr",  32'(last_perr[2]),    32'(rv[i].perr));
            check("par_rx_ferr",  32'(last_ferr[2]),    32'd0);
        end

        // Stop bit low followed by a 5-bit-time break, then a clean frame.
        loop0 = 1'b0;
        r0 = rxv_cnt[0];
        rx_drive(0, 12'b00_0_01011010_0, 10);
        repeat (5 * 64) @(negedge clk);
        check("brk_rx_valid", 32'(rxv_cnt[0] - r0), 32'd1);
        check("brk_ferr",     32'(last_ferr[0]),    32'd1);
        check("brk_perr",     32'(last_perr[0]),    32'd0);
        check("brk_data",     32'(last_data[0]),    32'h5A);
        rx_drv0 = 1'b1;
        repeat (128) @(negedge clk);
        rx_drive(0, 12'b00_1_11000011_0, 10);
        repeat (8) @(negedge clk);
        check("post_brk_valid", 32'(rxv_cnt[0] - r0), 32'd2);
        check("post_brk_data",  32'(last_data[0]),    32'hC3);
        check("post_brk_ferr",  32'(last_ferr[0]),    32'd0);

        // 4-tick glitch is a false start.
        r0 = rxv_cnt[0];
        rx_drv0 = 1'b0;
        repeat (16) @(negedge clk);
        rx_drv0 = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_no_valid", 32'(rxv_cnt[0] - r0), 32'd0);
        rx_drive(0, 12'b00_1_10010110_0, 10);
        repeat (8) @(negedge clk);
        check("post_glitch_valid", 32'(rxv_cnt[0] - r0), 32'd1);
        check("post_glitch_data",  32'(last_data[0]),    32'h96);

        // Reset in the middle of a looped-back frame.
        loop0 = 1'b1;
        @(negedge clk);
        tx_data[0] = 9'h00F; tx_valid[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (ready_w[0]) break;
            @(negedge clk);
        end
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (200) @(negedge clk);
        r0 = rxv_cnt[0];
        rst_n = 1'b0;
        #1;
        check("midrst_tx",      32'(tx_w[0]),    32'd1);
        check("midrst_txready", 32'(ready_w[0]), 32'd1);
        check("midrst_rxdata",  32'(rxd0),       32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("midrst_no_valid", 32'(rxv_cnt[0] - r0), 32'd0);
        run_vec(e7);
        run_vec(tv[8]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/uart_param_core.md
# uart_param_core

Parametrised full-duplex UART core: configurable data width, parity and stop bits, a runtime baud divisor, a valid/ready transmit handshake, and per-frame receive error flags. It is the next-generation replacement for the fixed 8N1 serial link. It sits between the NPU command/data path and the external serial module (HC-06 at 9600 baud). All timing derives from one shared 16x-oversampling tick.

## Interface
Parameters:
- DATA_W, 8: data bits per frame, legal 5..9
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2
- DIV_W, 16: width of the baud divisor

Ports:
- Clk  in  1  system clock; single clock domain
- Rst_n  in  1  asynchronous active-low reset
- BaudDiv  in  DIV_W  tick period minus 1, in Clk cycles; tick rate = 16 x baud (325 at 50 MHz gives 9600 baud)
- TxData  in  DATA_W  word to send, LSB first
- TxValid  in  1  TxData is valid
- TxReady  out  1  transmitter idle; word accepted when TxValid and TxReady
- TxDone  out  1  one-cycle pulse at the end of the last stop bit
- Tx  out  1  serial output, idle high
- Rx  in  1  serial input, asynchronous
- RxData  out  DATA_W  last received word; held until the next frame completes
- RxValid  out  1  one-cycle pulse when a frame completes
- RxParityErr  out  1  valid with RxValid: parity mismatch
- RxFrameErr  out  1  valid with RxValid: first stop bit sampled low

## Operation
- Tick generator: a counter reloads from BaudDiv and pulses tick for one cycle when it reaches 0. BaudDiv=0 gives a tick every cycle. BaudDiv changes take effect at the next reload. Software changes BaudDiv only while TxReady=1 and the receiver is idle.
- TX FSM: IDLE, START, DATA, PARITY, STOP.
  - TxReady=1 only in IDLE.
  - On acceptance, TxData is latched and the FSM enters START.
  - Each state holds for 16 ticks.
  - DATA shifts DATA_W bits, LSB first.
  - PARITY exists only if PARITY!=0. Odd parity means the total count of ones in data plus parity is odd.
  - STOP lasts STOP_BITS x 16 ticks.
  - TxDone pulses on the last tick of STOP; the FSM returns to IDLE in the same cycle.
  - TxValid while the FSM is busy is ignored, and the word is not consumed.
- RX path: Rx passes through a 2-flop synchroniser, reset value 1.
- RX FSM: IDLE, START, DATA, PARITY, STOP, BREAK.
  - In IDLE, a synchronised low starts the tick count.
  - At tick 7 (mid-bit), a sampled low commits to the frame. A sampled high is a false start and returns the FSM to IDLE with no flags.
  - Data, parity and stop bits are each sampled at tick 7 of their 16-tick window, LSB first.
  - Only the first stop bit is checked; the second is not sampled.
  - At the stop-bit sample point, RxData is updated and RxValid pulses together with both error flags. This happens even on error, so error frames are reported.
  - On a frame error the FSM enters BREAK and waits for the synchronised line to go high before returning to IDLE.
  - Error flags drop to 0 when RxValid drops.
- TX and RX run fully independently, sharing only the tick.

## Timing
- Reset values: Tx=1, TxReady=1, TxDone=0, RxData=0, RxValid=0, RxParityErr=0, RxFrameErr=0. Both FSMs go to IDLE and the tick counter loads BaudDiv.
- Tx falls in the cycle after acceptance. The start bit lasts 16 ticks minus 0..BaudDiv cycles, because of prescaler phase.
- TX frame length: (1 + DATA_W + (PARITY!=0) + STOP_BITS) x 16 ticks.
- TxReady returns to 1 in the cycle after TxDone. Back-to-back words therefore have no idle gap beyond one cycle.
- RX latency: from the Rx falling edge to RxValid is 2 cycles of synchroniser delay plus (1 + DATA_W + (PARITY!=0)) x 16 + 8 ticks.
- Reset mid-frame: Tx returns high immediately, and a partial RX frame is discarded with no RxValid.
- Simultaneous TxValid and the final TxDone cycle: not accepted; TxReady is still 0.

## Structure
- Package uart_pkg holds:
  - the parity_e enum (NONE, ODD, EVEN)
  - the tx_state_e and rx_state_e enums
  - the constant OVERSAMPLE=16 and the constant MID_SAMPLE=7
- One sub-module, uart_tick_gen (Clk, Rst_n, BaudDiv, Tick), shared by the TX and RX FSMs.
- TX and RX FSMs stay in uart_param_core.

## Test plan
- Default 8N1, BaudDiv=3: send 8'hA5 -> Tx shows 0,1,0,1,0,0,1,0,1,1 with each bit 64 cycles; TxDone pulses once; loopback RxData=8'hA5, RxValid once, no errors.
- DATA_W=7, PARITY=2, STOP_BITS=2: send 7'h55 -> parity bit 0, two stop bits, frame 11x16 ticks; loopback with no error.
- PARITY=1: inject 8'h01 with parity bit 0 -> RxValid with RxParityErr=1 and RxData=8'h01.
- Hold the stop bit low, then keep Rx low for 5 bit times -> a single RxValid with RxFrameErr=1, no further frames until Rx returns high.
- Rx glitch low for 4 ticks -> no RxValid, FSM back in IDLE.
- Assert Rst_n low mid-DATA -> Tx=1 and TxReady=1 at once; after release, the next word is sent correctly and no RxValid appears from the partial frame.
